// File: rtl/maxpool_reader_pkg.sv
// Shared definitions for the max-pool reader slice.
//   state_t   : FSM states (IDLE / READ / WRITE / DONE)
//   cnt_w     : counter width for a range of n values (minimum 1 bit)
//   fmap_addr : channel-interleaved feature-map address (y*width + x)*channels + ch
package maxpool_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned fmap_addr(input int unsigned x, input int unsigned y,
                                            input int unsigned ch, input int unsigned width,
                                            input int unsigned channels);
    return (y * width + x) * channels + ch;
  endfunction

endpackage

// File: rtl/maxpool_reader_if.sv
// Handshake and memory-port bundle of the max-pool reader.
//   axisif_start / axisif_done : start pulse in, one-cycle completion pulse out
//   out_adrIn / in_dataIn      : read port into the conv output RAM (data is combinational)
//   out_adrOut / out_dataOut / out_wr : write port into the next-layer buffer
// master = the reader itself, slave = the surrounding RAMs / controller.
interface maxpool_reader_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IN_ADR_WIDTH  = 32,
  parameter int unsigned OUT_ADR_WIDTH = 32
);
  logic                            axisif_start;
  logic                            axisif_done;
  logic [IN_ADR_WIDTH-1:0]         out_adrIn;
  logic signed [DATA_WIDTH-1:0]    in_dataIn;
  logic [OUT_ADR_WIDTH-1:0]        out_adrOut;
  logic signed [DATA_WIDTH-1:0]    out_dataOut;
  logic                            out_wr;

  modport master (
    input  axisif_start, in_dataIn,
    output axisif_done, out_adrIn, out_adrOut, out_dataOut, out_wr
  );

  modport slave (
    output axisif_start, in_dataIn,
    input  axisif_done, out_adrIn, out_adrOut, out_dataOut, out_wr
  );
endinterface

// File: rtl/maxpool_reader_pool_window_counter.sv
// Nested window walker: py, px, ch, ky, kx (outermost to innermost).
//   advance     : step to the next element; the whole nest wraps to zero after the last one
//   kx..py      : current position
//   first_elem  : kx = ky = 0
//   last_elem   : kx = ky = POOL-1
//   last_window : py, px, ch all at their final value
module pool_window_counter
  import maxpool_reader_pkg::*;
#(
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned OUT_H   = 2,
  parameter int unsigned CHANNEL = 2,
  parameter int unsigned POOL    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
  output logic [cnt_w(POOL)-1:0]      kx,
  output logic [cnt_w(POOL)-1:0]      ky,
  output logic [cnt_w(CHANNEL)-1:0]   ch,
  output logic [cnt_w(OUT_W)-1:0]     px,
  output logic [cnt_w(OUT_H)-1:0]     py,
  output logic                        first_elem,
  output logic                        last_elem,
  output logic                        last_window
);
  localparam int unsigned KW  = cnt_w(POOL);
  localparam int unsigned CW  = cnt_w(CHANNEL);
  localparam int unsigned PXW = cnt_w(OUT_W);
  localparam int unsigned PYW = cnt_w(OUT_H);

  logic [KW-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx_q <= '0;
      ky_q <= '0;
      ch_q <= '0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      ch_q <= ch_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    ch_d = ch_q;
    px_d = px_q;
    py_d = py_q;
    if (advance) begin
      if (kx_q != KW'(POOL - 1)) begin
        kx_d = kx_q + 1'b1;
      end else begin
        kx_d = '0;
        if (ky_q != KW'(POOL - 1)) begin
          ky_d = ky_q + 1'b1;
        end else begin
          ky_d = '0;
          if (ch_q != CW'(CHANNEL - 1)) begin
            ch_d = ch_q + 1'b1;
          end else begin
            ch_d = '0;
            if (px_q != PXW'(OUT_W - 1)) begin
              px_d = px_q + 1'b1;
            end else begin
              px_d = '0;
              py_d = (py_q != PYW'(OUT_H - 1)) ? py_q + 1'b1 : '0;
            end
          end
        end
      end
    end
  end

  assign kx          = kx_q;
  assign ky          = ky_q;
  assign ch          = ch_q;
  assign px          = px_q;
  assign py          = py_q;
  assign first_elem  = (kx_q == '0) && (ky_q == '0);
  assign last_elem   = (kx_q == KW'(POOL - 1)) && (ky_q == KW'(POOL - 1));
  assign last_window = (ch_q == CW'(CHANNEL - 1)) && (px_q == PXW'(OUT_W - 1))
                    && (py_q == PYW'(OUT_H - 1));
endmodule

// File: rtl/maxpool_reader.sv
// Non-overlapping POOL x POOL max pooling over a channel-interleaved feature map.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : maxpool_reader_if.master (start/done, read port, write port)
// Each window is read over POOL*POOL cycles, then written in one WRITE cycle while
// the read address already presents the next window's first element.
module maxpool_reader
  import maxpool_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IN_ADR_WIDTH  = 32,
  parameter int unsigned OUT_ADR_WIDTH = 32,
  parameter int unsigned IN_WIDTH      = 4,
  parameter int unsigned IN_HEIGHT     = 4,
  parameter int unsigned CHANNEL       = 2,
  parameter int unsigned POOL          = 2
) (
  input  logic              clk,
  input  logic              rst,
  maxpool_reader_if.master  bus
);
  localparam int unsigned OUT_W = IN_WIDTH / POOL;
  localparam int unsigned OUT_H = IN_HEIGHT / POOL;

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] max_q, max_d, data_q, data_d, max_upd;
  logic [OUT_ADR_WIDTH-1:0]     adr_out_q, adr_out_d;
  logic                         last_q, last_d;

  logic                         advance, first_elem, last_elem, last_window;
  logic [cnt_w(POOL)-1:0]       kx, ky;
  logic [cnt_w(CHANNEL)-1:0]    ch;
  logic [cnt_w(OUT_W)-1:0]      px;
  logic [cnt_w(OUT_H)-1:0]      py;
  int unsigned                  rd_adr, wr_adr;

  pool_window_counter #(
    .OUT_W   (OUT_W),
    .OUT_H   (OUT_H),
    .CHANNEL (CHANNEL),
    .POOL    (POOL)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .kx          (kx),
    .ky          (ky),
    .ch          (ch),
    .px          (px),
    .py          (py),
    .first_elem  (first_elem),
    .last_elem   (last_elem),
    .last_window (last_window)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      max_q     <= '0;
      data_q    <= '0;
      adr_out_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      data_q    <= data_d;
      adr_out_q <= adr_out_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.axisif_start) state_d = READ;
      READ:    if (last_elem) state_d = WRITE;
      WRITE:   state_d = last_q ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath
  always_comb begin
    rd_adr  = fmap_addr(32'(px) * POOL + 32'(kx), 32'(py) * POOL + 32'(ky), 32'(ch),
                        IN_WIDTH, CHANNEL);
    wr_adr  = fmap_addr(32'(px), 32'(py), 32'(ch), OUT_W, CHANNEL);
    // First element of a window loads directly; later ones only on strictly greater.
    max_upd = (first_elem || (bus.in_dataIn > max_q)) ? bus.in_dataIn : max_q;

    advance   = (state_q == READ);
    max_d     = max_q;
    data_d    = data_q;
    adr_out_d = adr_out_q;
    last_d    = last_q;
    if (state_q == READ) begin
      max_d = max_upd;
      // The counter moves past this window on the same edge, so the write
      // address and the last-window flag are captured here.
      if (last_elem) begin
        data_d    = max_upd;
        adr_out_d = OUT_ADR_WIDTH'(wr_adr);
        last_d    = last_window;
      end
    end

    bus.out_adrIn   = (state_q == IDLE) ? '0 : IN_ADR_WIDTH'(rd_adr);
    bus.out_wr      = (state_q == WRITE);
    bus.out_dataOut = data_q;
    bus.out_adrOut  = adr_out_q;
    bus.axisif_done = (state_q == DONE);
  end
endmodule

// File: tb/tb_maxpool_reader.sv
// Bench for maxpool_reader: a 4x4x2 instance (a) and a 5x5x1 instance (b), both
// POOL = 2, each reading from a bench-owned memory. Expected writes come from a
// window-by-window max over that memory.
module tb_maxpool_reader;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] mem_a [32];
  logic signed [31:0] mem_b [25];

  maxpool_reader_if #(.DATA_WIDTH(32), .IN_ADR_WIDTH(32), .OUT_ADR_WIDTH(32)) if_a ();
  maxpool_reader_if #(.DATA_WIDTH(32), .IN_ADR_WIDTH(32), .OUT_ADR_WIDTH(32)) if_b ();

  maxpool_reader #(
    .DATA_WIDTH(32), .IN_ADR_WIDTH(32), .OUT_ADR_WIDTH(32),
    .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNEL(2), .POOL(2)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

  maxpool_reader #(
    .DATA_WIDTH(32), .IN_ADR_WIDTH(32), .OUT_ADR_WIDTH(32),
    .IN_WIDTH(5), .IN_HEIGHT(5), .CHANNEL(1), .POOL(2)
  ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

  assign if_a.in_dataIn = (if_a.out_adrIn < 32) ? mem_a[if_a.out_adrIn[4:0]] : 32'sd0;
  assign if_b.in_dataIn = (if_b.out_adrIn < 25) ? mem_b[if_b.out_adrIn[4:0]] : 32'sd0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dim_w(input int sel); return sel ? 5 : 4; endfunction
  function automatic int dim_h(input int sel); return sel ? 5 : 4; endfunction
  function automatic int dim_c(input int sel); return sel ? 1 : 2; endfunction

  function automatic logic signed [31:0] rd_mem(input int sel, input int a);
    return sel ? mem_b[a] : mem_a[a];
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) if_b.axisif_start = v;
    else          if_a.axisif_start = v;
  endtask

  task automatic sample(input int sel, output logic wr, output logic done,
                        output logic signed [31:0] data, output logic [31:0] adr_out,
                        output logic [31:0] adr_in);
    if (sel != 0) begin
      wr = if_b.out_wr; done = if_b.axisif_done; data = if_b.out_dataOut;
      adr_out = if_b.out_adrOut; adr_in = if_b.out_adrIn;
    end else begin
      wr = if_a.out_wr; done = if_a.axisif_done; data = if_a.out_dataOut;
      adr_out = if_a.out_adrOut; adr_in = if_a.out_adrIn;
    end
  endtask

  // One start/done operation; restart_k pulses start again while busy,
  // rst_k asserts reset at that cycle and ends the run there.
  task automatic run_op(input string name, input int sel, input int restart_k, input int rst_k);
    logic signed [31:0] exp_val[$], got_val[$];
    int                 exp_adr[$], got_adr[$];
    int w, h, c, ow, oh, n, exp_done, done_k, done_cnt, bad, pos, x, y;
    logic signed [31:0] m, v, prev_data, data;
    logic [31:0] prev_adr, adr_out, adr_in;
    logic wr, done;

    w = dim_w(sel); h = dim_h(sel); c = dim_c(sel);
    ow = w / P; oh = h / P;
    for (int py = 0; py < oh; py++)
      for (int px = 0; px < ow; px++)
        for (int ch = 0; ch < c; ch++) begin
          m = '0;
          for (int ky = 0; ky < P; ky++)
            for (int kx = 0; kx < P; kx++) begin
              v = rd_mem(sel, ((py * P + ky) * w + px * P + kx) * c + ch);
              if ((ky == 0 && kx == 0) || v > m) m = v;
            end
          exp_val.push_back(m);
          exp_adr.push_back((py * ow + px) * c + ch);
        end
    n = exp_val.size();
    exp_done = n * (P * P + 1) + 1;
    done_k = -1; done_cnt = 0; bad = 0;

    @(negedge clk);
    sample(sel, wr, done, prev_data, prev_adr, adr_in);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 1; k <= exp_done + 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == restart_k + 1) set_start(sel, 1'b0);
      sample(sel, wr, done, data, adr_out, adr_in);
      if (wr) begin
        got_val.push_back(data);
        got_adr.push_back(int'(adr_out));
      end else begin
        check_val({name, "_hold_data"}, data, prev_data);
        check_val({name, "_hold_adr"}, adr_out, prev_adr);
      end
      prev_data = data; prev_adr = adr_out;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      pos = int'(adr_in) / c;
      x = pos % w; y = pos / w;
      if (x >= ow * P || y >= oh * P) bad++;
      if (k == restart_k) set_start(sel, 1'b1);
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        sample(sel, wr, done, data, adr_out, adr_in);
        check_val({name, "_rst_wr"}, wr, 0);
        check_val({name, "_rst_done"}, done, 0);
        check_val({name, "_rst_data"}, data, 0);
        check_val({name, "_rst_adrout"}, adr_out, 0);
        check_val({name, "_rst_adrin"}, adr_in, 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          sample(sel, wr, done, data, adr_out, adr_in);
          if (wr || done) done_cnt++;
        end
        check_val({name, "_rst_quiet"}, done_cnt, 0);
        check_val({name, "_rst_nwr"}, got_val.size(), rst_k / (P * P + 1));
        for (int i = 0; i < got_val.size() && i < n; i++) begin
          check_val({name, "_rst_val"}, got_val[i], exp_val[i]);
          check_val({name, "_rst_adr"}, got_adr[i], exp_adr[i]);
        end
        return;
      end
    end
    check_val({name, "_nwr"}, got_val.size(), n);
    for (int i = 0; i < got_val.size() && i < n; i++) begin
      check_val({name, "_val"}, got_val[i], exp_val[i]);
      check_val({name, "_adr"}, got_adr[i], exp_adr[i]);
    end
    check_val({name, "_done_k"}, done_k, exp_done);
    check_val({name, "_done_cnt"}, done_cnt, 1);
    check_val({name, "_bad_rd"}, bad, 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) mem_a[i] = i;
    for (int i = 0; i < 25; i++) mem_b[i] = i;
  endtask

  initial begin
    logic wr, done;
    logic signed [31:0] data;
    logic [31:0] adr_out, adr_in;
    int wi;

    if_a.axisif_start = 1'b0;
    if_b.axisif_start = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, wr, done, data, adr_out, adr_in);
      check_val("reset_wr", wr, 0);
      check_val("reset_done", done, 0);
      check_val("reset_data", data, 0);
      check_val("reset_adrout", adr_out, 0);
      check_val("reset_adrin", adr_in, 0);
    end
    rst = 1'b0;

    run_op("ramp", 0, -1, -1);
    run_op("odd", 1, -1, -1);

    for (int i = 0; i < 32; i++) mem_a[i] = -i - 1;
    run_op("neg", 0, -1, -1);

    // Single peak per window, moving through (kx,ky) = (0,0),(1,0),(0,1),(1,1).
    for (int i = 0; i < 32; i++) mem_a[i] = 7;
    wi = 0;
    for (int py = 0; py < 2; py++)
      for (int px = 0; px < 2; px++)
        for (int ch = 0; ch < 2; ch++) begin
          mem_a[((py * P + (wi % 4) / 2) * 4 + px * P + (wi % 4) % 2) * 2 + ch] = 100;
          wi++;
        end
    run_op("peak", 0, -1, -1);

    fill_ramp();
    run_op("busy", 0, 5, -1);
    run_op("rstmid", 0, -1, 12);
    run_op("fresh", 0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++)
        mem_a[i] = (r % 2 == 0) ? $signed($urandom) : $signed(32'($urandom_range(0, 7)) - 32'd4);
      for (int i = 0; i < 25; i++)
        mem_b[i] = (r % 2 == 0) ? $signed($urandom) : $signed(32'($urandom_range(0, 7)) - 32'd4);
      run_op("rand_a", 0, -1, -1);
      run_op("rand_b", 1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
